mips_exec_mem_unit: RTL and testbench
=====================================

Name: mips_exec_mem_unit

Overview:
- Combined execute/memory stage of the single-cycle MIPS-32 datapath: main control decoder, ALU and data memory in one block.
- Takes the decoded instruction fields plus the two register-file read values.
- Produces register-file and memory control signals, the ALU result, load data, and the register write-back value (ALU result or load data).
- The PC logic uses the branch flag and write-back value; on a taken branch, write-back carries the byte offset.

Parameters:
MEM_ADDR_W, 8, word-address width of data memory (2^MEM_ADDR_W 32-bit words, default 1 KiB)

Ports:
clk  in  1  clock; memory writes on rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
immediate  in  16  instruction[15:0]; shamt = immediate[10:6]
rs_reg  in  32  rs register value
rt_reg  in  32  rt register value; store data
RegWrite  out  1  register file write enable
RegRead  out  1  register file read enable
MemRead  out  1  load in progress
MemWrite  out  1  store in progress
toReg  out  1  write-back select: 0 = ALU, 1 = memory
rt_rd  out  1  destination select: 1 = rd, 0 = rt
Branch  out  1  conditional branch taken
alu_result  out  32  ALU output / memory byte address
mem_read_data  out  32  extended load data
write_data  out  32  write-back value: toReg ? mem_read_data : alu_result

Behaviour:
- All outputs are combinational functions of the inputs and memory contents; no pipeline latency.
- Unrecognised opcode or funct: every control output 0, alu_result 0.
- R-type (opcode 000000):
  - RegWrite = 1, RegRead = 1, rt_rd = 1, toReg = 0.
  - funct 100000/100001 add/addu: rs + rt, wrapping; no overflow trap.
  - 100010/100011 sub/subu: rs - rt, wrapping.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed compare), 101011 sltu (unsigned compare); result is 1 or 0.
  - 000000 sll, 000010 srl, 000011 sra: operate on rt by shamt.
  - 001000 jr: RegWrite = 0, RegRead = 1, alu_result = rs.
- I-type ALU ops (RegWrite = 1, RegRead = 1, rt_rd = 0, toReg = 0):
  - 001000 addi / 001001 addiu: rs + sext(imm).
  - 001010 slti / 001011 sltiu: compare rs against sext(imm).
  - 001100 andi, 001101 ori, 001110 xori: use zero-extended imm.
  - 001111 lui: {imm, 16'h0}.
- Branches 000100 beq / 000101 bne:
  - RegWrite = 0, RegRead = 1.
  - Branch = 1 when (rs == rt) for beq, or (rs != rt) for bne.
  - If taken: alu_result = sext(imm) << 2. If not taken: alu_result = 0.
- Jumps: 000010 j has all controls 0. 000011 jal has RegWrite = 1, all other controls 0, alu_result = 0; the register file supplies the link value.
- Loads (RegWrite = 1, RegRead = 1, MemRead = 1, toReg = 1, rt_rd = 0):
  - 100011 lw, 100000 lb, 100100 lbu, 100001 lh, 100101 lhu.
  - Address = rs + sext(imm).
- Stores (MemWrite = 1, RegRead = 1, RegWrite = 0):
  - 101011 sw, 101000 sb, 101001 sh.
  - Same address computation as loads.
- Memory organisation:
  - Little-endian, byte-addressed.
  - Word index = addr[MEM_ADDR_W+1:2]; upper address bits are ignored, so addresses wrap.
  - Word accesses ignore addr[1:0]. Halfword accesses use addr[1] and ignore addr[0].
  - Byte lanes: byte 0 = bits 7:0, lane n at bits 8n+7:8n.
- Memory read:
  - Combinational.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - mem_read_data = 0 when MemRead = 0.
- Memory write:
  - At rising clk when MemWrite = 1 and rst = 0.
  - sb writes only the addressed byte lane with rt[7:0]; sh writes the addressed halfword with rt[15:0]; sw writes the full word.
- Reset:
  - At a rising clk with rst = 1, every memory word is cleared to 0 and any store that cycle is suppressed.
  - Combinational control and ALU outputs are unaffected by rst.
  - Loads after reset return 0.
- Load and store to the same address in one cycle: the load returns the old data; the new data is visible from the next cycle.

Test Plan:
- Reset, then lw at rs = 0x0, imm = 0x10 -> MemRead = 1, toReg = 1, alu_result = 0x10, mem_read_data = 0, write_data = 0.
- sw with rs = 0x100, imm = 0xFFFC, rt = 0xDEADBEEF, then lw at the same address -> alu_result = 0xFC, read returns 0xDEADBEEF; a subsequent lb at 0xFF returns 0xFFFFFFDE, and lbu at 0xFC returns 0x000000EF.
- R-type add with rs = 0x7FFFFFFF, rt = 1 -> 0x80000000, RegWrite = 1, rt_rd = 1. slt with rs = -1, rt = 1 -> 1. sltu with the same operands -> 0. sra with rt = 0x80000000, shamt = 4 -> 0xF8000000.
- beq with rs = rt = 5, imm = 0xFFFE -> Branch = 1, write_data = 0xFFFFFFF8. bne with the same inputs -> Branch = 0.
- lui with imm = 0x1234 -> 0x12340000. ori with rs = 0x12340000, imm = 0x8001 -> 0x12348001.
- sb 0xAB to address 0x3 of a zeroed word, then lw -> 0xAB000000. Assert rst during a sw -> the word stays 0.

Source files
------------

// File: rtl/mips_exec_mem_unit_if.sv
// Operand/control bundle between the decode side and the execute/memory stage.
interface mips_exec_mem_unit_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [31:0] rs_reg;
    logic [31:0] rt_reg;
    logic        RegWrite;
    logic        RegRead;
    logic        MemRead;
    logic        MemWrite;
    logic        toReg;
    logic        rt_rd;
    logic        Branch;
    logic [31:0] alu_result;
    logic [31:0] mem_read_data;
    logic [31:0] write_data;

    modport master (
        output opcode, funct, immediate, rs_reg, rt_reg,
        input  RegWrite, RegRead, MemRead, MemWrite, toReg, rt_rd,
        input  Branch, alu_result, mem_read_data, write_data
    );

    modport slave (
        input  opcode, funct, immediate, rs_reg, rt_reg,
        output RegWrite, RegRead, MemRead, MemWrite, toReg, rt_rd,
        output Branch, alu_result, mem_read_data, write_data
    );
endinterface

// File: rtl/mips_exec_mem_unit.sv
// Single-cycle MIPS-32 execute/memory stage: control decode, ALU and
// little-endian byte-addressed data memory with combinational reads.
module mips_exec_mem_unit #(
    parameter int MEM_ADDR_W = 8
) (
    input logic clk,
    input logic rst,
    mips_exec_mem_unit_if.slave bus
);
    localparam int DEPTH = 1 << MEM_ADDR_W;

    typedef enum logic [2:0] {LD_NONE, LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_e;
    typedef enum logic [1:0] {ST_NONE, ST_W, ST_H, ST_B} st_e;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] rs, rt, sext, zext, alu;
    logic [4:0]  shamt;
    logic        reg_write, reg_read, mem_read, mem_write;
    logic        to_reg, rt_rd, branch, r_ok, taken;
    ld_e         ld_kind;
    st_e         st_kind;

    logic [MEM_ADDR_W-1:0] widx;
    logic [31:0] rd_word, ld_data, wr_word_d;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;

    assign rs    = bus.rs_reg;
    assign rt    = bus.rt_reg;
    assign sext  = {{16{bus.immediate[15]}}, bus.immediate};
    assign zext  = {16'h0, bus.immediate};
    assign shamt = bus.immediate[10:6];
    assign taken = bus.opcode[0] ? (rs != rt) : (rs == rt);

    always_comb begin
        reg_write = 1'b0;
        reg_read  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        to_reg    = 1'b0;
        rt_rd     = 1'b0;
        branch    = 1'b0;
        r_ok      = 1'b1;
        alu       = '0;
        ld_kind   = LD_NONE;
        st_kind   = ST_NONE;
        unique case (bus.opcode)
            6'b000000: begin
                unique case (bus.funct)
                    6'b100000, 6'b100001: alu = rs + rt;
                    6'b100010, 6'b100011: alu = rs - rt;
                    6'b100100: alu = rs & rt;
                    6'b100101: alu = rs | rt;
                    6'b100110: alu = rs ^ rt;
                    6'b100111: alu = ~(rs | rt);
                    6'b101010: alu = {31'b0, $signed(rs) < $signed(rt)};
                    6'b101011: alu = {31'b0, rs < rt};
                    6'b000000: alu = rt << shamt;
                    6'b000010: alu = rt >> shamt;
                    6'b000011: alu = $signed(rt) >>> shamt;
                    6'b001000: alu = rs;
                    default:   r_ok = 1'b0;
                endcase
                reg_read = r_ok;
                // jr only reads rs; everything else writes rd
                if (r_ok && bus.funct != 6'b001000) begin
                    reg_write = 1'b1;
                    rt_rd     = 1'b1;
                end
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                reg_write = 1'b1;
                reg_read  = 1'b1;
                unique case (bus.opcode[2:0])
                    3'b000, 3'b001: alu = rs + sext;
                    3'b010: alu = {31'b0, $signed(rs) < $signed(sext)};
                    3'b011: alu = {31'b0, rs < sext};
                    3'b100: alu = rs & zext;
                    3'b101: alu = rs | zext;
                    3'b110: alu = rs ^ zext;
                    default: alu = {bus.immediate, 16'h0};
                endcase
            end
            6'b000100, 6'b000101: begin
                reg_read = 1'b1;
                branch   = taken;
                alu      = taken ? (sext << 2) : '0;
            end
            6'b000010: ;
            6'b000011: reg_write = 1'b1;
            6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101: begin
                reg_write = 1'b1;
                reg_read  = 1'b1;
                mem_read  = 1'b1;
                to_reg    = 1'b1;
                alu       = rs + sext;
                unique case (bus.opcode[2:0])
                    3'b011:  ld_kind = LD_W;
                    3'b000:  ld_kind = LD_B;
                    3'b100:  ld_kind = LD_BU;
                    3'b001:  ld_kind = LD_H;
                    default: ld_kind = LD_HU;
                endcase
            end
            6'b101011, 6'b101000, 6'b101001: begin
                mem_write = 1'b1;
                reg_read  = 1'b1;
                alu       = rs + sext;
                unique case (bus.opcode[1:0])
                    2'b11:   st_kind = ST_W;
                    2'b01:   st_kind = ST_H;
                    default: st_kind = ST_B;
                endcase
            end
            default: ;
        endcase
    end

    assign widx    = alu[MEM_ADDR_W+1:2];
    assign rd_word = mem_q[widx];
    assign rd_half = alu[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        unique case (alu[1:0])
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        unique case (ld_kind)
            LD_W:    ld_data = rd_word;
            LD_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
            LD_BU:   ld_data = {24'h0, rd_byte};
            LD_H:    ld_data = {{16{rd_half[15]}}, rd_half};
            LD_HU:   ld_data = {16'h0, rd_half};
            default: ld_data = '0;
        endcase
    end

    // Partial stores merge into the current word contents
    always_comb begin
        wr_word_d = rd_word;
        unique case (st_kind)
            ST_W: wr_word_d = rt;
            ST_H: begin
                if (alu[1]) wr_word_d[31:16] = rt[15:0];
                else        wr_word_d[15:0]  = rt[15:0];
            end
            ST_B: begin
                unique case (alu[1:0])
                    2'b00:   wr_word_d[7:0]   = rt[7:0];
                    2'b01:   wr_word_d[15:8]  = rt[7:0];
                    2'b10:   wr_word_d[23:16] = rt[7:0];
                    default: wr_word_d[31:24] = rt[7:0];
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_write) begin
            mem_q[widx] <= wr_word_d;
        end
    end

    assign bus.RegWrite      = reg_write;
    assign bus.RegRead       = reg_read;
    assign bus.MemRead       = mem_read;
    assign bus.MemWrite      = mem_write;
    assign bus.toReg         = to_reg;
    assign bus.rt_rd         = rt_rd;
    assign bus.Branch        = branch;
    assign bus.alu_result    = alu;
    assign bus.mem_read_data = ld_data;
    assign bus.write_data    = to_reg ? ld_data : alu;
endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Bench for mips_exec_mem_unit: directed literal checks plus random
// instructions compared every cycle against a byte-array reference model.
module tb_mips_exec_mem_unit;
    localparam int NBYTES = 1024;

    typedef struct packed {
        logic        rw, rr, mr, mw, tr, rd, br;
        logic [31:0] alu, mrd, wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] mb [NBYTES];

    mips_exec_mem_unit_if bus ();

    mips_exec_mem_unit #(.MEM_ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mload(input logic [5:0] op,
                                          input logic [31:0] a);
        int unsigned w, h, y;
        logic [15:0] hv;
        w  = {22'b0, a[9:2], 2'b00};
        h  = w + (a[1] ? 2 : 0);
        y  = {22'b0, a[9:0]};
        hv = {mb[h+1], mb[h]};
        case (op)
            6'h23:   return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
            6'h20:   return {{24{mb[y][7]}}, mb[y]};
            6'h24:   return {24'h0, mb[y]};
            6'h21:   return {{16{hv[15]}}, hv};
            default: return {16'h0, hv};
        endcase
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [15:0] imm,
                                   input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [31:0] se, ze, a;
        int sh;
        e  = '0;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        sh = int'(imm[10:6]);
        a  = rs + se;
        case (op)
            6'h00: begin
                e.rw = 1; e.rr = 1; e.rd = 1;
                case (fn)
                    6'h20, 6'h21: e.alu = rs + rt;
                    6'h22, 6'h23: e.alu = rs - rt;
                    6'h24: e.alu = rs & rt;
                    6'h25: e.alu = rs | rt;
                    6'h26: e.alu = rs ^ rt;
                    6'h27: e.alu = ~(rs | rt);
                    6'h2a: e.alu = ($signed(rs) < $signed(rt)) ? 1 : 0;
                    6'h2b: e.alu = (rs < rt) ? 1 : 0;
                    6'h00: e.alu = rt << sh;
                    6'h02: e.alu = rt >> sh;
                    6'h03: e.alu = $signed(rt) >>> sh;
                    6'h08: begin e.rw = 0; e.rd = 0; e.alu = rs; end
                    default: e = '0;
                endcase
            end
            6'h08, 6'h09: begin e.rw = 1; e.rr = 1; e.alu = rs + se; end
            6'h0a: begin e.rw = 1; e.rr = 1; e.alu = ($signed(rs) < $signed(se)) ? 1 : 0; end
            6'h0b: begin e.rw = 1; e.rr = 1; e.alu = (rs < se) ? 1 : 0; end
            6'h0c: begin e.rw = 1; e.rr = 1; e.alu = rs & ze; end
            6'h0d: begin e.rw = 1; e.rr = 1; e.alu = rs | ze; end
            6'h0e: begin e.rw = 1; e.rr = 1; e.alu = rs ^ ze; end
            6'h0f: begin e.rw = 1; e.rr = 1; e.alu = {imm, 16'h0}; end
            6'h04, 6'h05: begin
                e.rr  = 1;
                e.br  = (op == 6'h04) ? (rs == rt) : (rs != rt);
                e.alu = e.br ? se * 4 : 0;
            end
            6'h03: e.rw = 1;
            6'h23, 6'h20, 6'h24, 6'h21, 6'h25: begin
                e.rw = 1; e.rr = 1; e.mr = 1; e.tr = 1;
                e.alu = a;
                e.mrd = mload(op, a);
            end
            6'h2b, 6'h28, 6'h29: begin e.mw = 1; e.rr = 1; e.alu = a; end
            default: ;
        endcase
        e.wd = e.tr ? e.mrd : e.alu;
        return e;
    endfunction

    // Reference memory update on each rising edge
    always @(posedge clk) begin
        logic [31:0] a;
        int unsigned b;
        a = bus.rs_reg + {{16{bus.immediate[15]}}, bus.immediate};
        b = {22'b0, a[9:0]};
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
        end else begin
            case (bus.opcode)
                6'h2b: for (int k = 0; k < 4; k++)
                           mb[(b & ~3) + k] = bus.rt_reg[8*k +: 8];
                6'h29: for (int k = 0; k < 2; k++)
                           mb[(b & ~1) + k] = bus.rt_reg[8*k +: 8];
                6'h28: mb[b] = bus.rt_reg[7:0];
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = model(bus.opcode, bus.funct, bus.immediate, bus.rs_reg, bus.rt_reg);
            cmp("RegWrite", {31'b0, bus.RegWrite}, {31'b0, e.rw});
            cmp("RegRead", {31'b0, bus.RegRead}, {31'b0, e.rr});
            cmp("MemRead", {31'b0, bus.MemRead}, {31'b0, e.mr});
            cmp("MemWrite", {31'b0, bus.MemWrite}, {31'b0, e.mw});
            cmp("toReg", {31'b0, bus.toReg}, {31'b0, e.tr});
            cmp("rt_rd", {31'b0, bus.rt_rd}, {31'b0, e.rd});
            cmp("Branch", {31'b0, bus.Branch}, {31'b0, e.br});
            cmp("alu_result", bus.alu_result, e.alu);
            cmp("mem_read_data", bus.mem_read_data, e.mrd);
            cmp("write_data", bus.write_data, e.wd);
        end
    end

    task automatic drive(input logic r, input logic [5:0] op,
                         input logic [5:0] fn, input logic [15:0] imm,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.immediate = imm;
        bus.rs_reg    = a;
        bus.rt_reg    = b;
        #3;
    endtask

    logic [5:0] ops [22];
    logic [5:0] fns [16];

    initial begin
        logic [5:0] op, fn;
        logic [31:0] a, b;
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h20,
                6'h24, 6'h21, 6'h25, 6'h2b, 6'h28, 6'h29};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h01, 6'h3f};
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
        bus.opcode = 6'h3f; bus.funct = 6'h0; bus.immediate = 16'h0;
        bus.rs_reg = '0; bus.rt_reg = '0;

        drive(1'b1, 6'h3f, 6'h00, 16'h0, 32'h0, 32'h0);
        chk_en = 1'b1;
        cmp("invalid_alu", bus.alu_result, 32'h0);
        cmp("invalid_regwrite", {31'b0, bus.RegWrite}, 32'h0);

        drive(1'b0, 6'h23, 6'h00, 16'h0010, 32'h0, 32'h0);
        cmp("reset_lw_memread", {31'b0, bus.MemRead}, 32'h1);
        cmp("reset_lw_toreg", {31'b0, bus.toReg}, 32'h1);
        cmp("reset_lw_addr", bus.alu_result, 32'h10);
        cmp("reset_lw_data", bus.mem_read_data, 32'h0);
        cmp("reset_lw_wd", bus.write_data, 32'h0);

        drive(1'b0, 6'h2b, 6'h00, 16'hFFFC, 32'h100, 32'hDEADBEEF);
        cmp("sw_addr", bus.alu_result, 32'hFC);
        drive(1'b0, 6'h23, 6'h00, 16'hFFFC, 32'h100, 32'h0);
        cmp("lw_back", bus.mem_read_data, 32'hDEADBEEF);
        drive(1'b0, 6'h20, 6'h00, 16'h0000, 32'hFF, 32'h0);
        cmp("lb_ff", bus.write_data, 32'hFFFFFFDE);
        drive(1'b0, 6'h24, 6'h00, 16'h0000, 32'hFC, 32'h0);
        cmp("lbu_fc", bus.write_data, 32'h000000EF);

        drive(1'b0, 6'h00, 6'h20, 16'h0, 32'h7FFFFFFF, 32'h1);
        cmp("add_ovf", bus.alu_result, 32'h80000000);
        cmp("add_rtrd", {31'b0, bus.rt_rd}, 32'h1);
        drive(1'b0, 6'h00, 6'h2a, 16'h0, 32'hFFFFFFFF, 32'h1);
        cmp("slt", bus.alu_result, 32'h1);
        drive(1'b0, 6'h00, 6'h2b, 16'h0, 32'hFFFFFFFF, 32'h1);
        cmp("sltu", bus.alu_result, 32'h0);
        drive(1'b0, 6'h00, 6'h03, 16'h0100, 32'h0, 32'h80000000);
        cmp("sra", bus.alu_result, 32'hF8000000);

        drive(1'b0, 6'h04, 6'h00, 16'hFFFE, 32'h5, 32'h5);
        cmp("beq_taken", {31'b0, bus.Branch}, 32'h1);
        cmp("beq_off", bus.write_data, 32'hFFFFFFF8);
        drive(1'b0, 6'h05, 6'h00, 16'hFFFE, 32'h5, 32'h5);
        cmp("bne_not", {31'b0, bus.Branch}, 32'h0);
        cmp("bne_alu", bus.alu_result, 32'h0);

        drive(1'b0, 6'h0f, 6'h00, 16'h1234, 32'h0, 32'h0);
        cmp("lui", bus.alu_result, 32'h12340000);
        drive(1'b0, 6'h0d, 6'h00, 16'h8001, 32'h12340000, 32'h0);
        cmp("ori", bus.alu_result, 32'h12348001);

        drive(1'b0, 6'h28, 6'h00, 16'h0003, 32'h0, 32'h000000AB);
        drive(1'b0, 6'h23, 6'h00, 16'h0000, 32'h0, 32'h0);
        cmp("sb_lane3", bus.mem_read_data, 32'hAB000000);
        drive(1'b1, 6'h2b, 6'h00, 16'h0040, 32'h0, 32'hFFFFFFFF);
        drive(1'b0, 6'h23, 6'h00, 16'h0040, 32'h0, 32'h0);
        cmp("rst_blocks_sw", bus.mem_read_data, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            op = ($urandom_range(0, 19) == 0) ? 6'($urandom) : ops[$urandom_range(0, 21)];
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
            a  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63));
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive($urandom_range(0, 63) == 0, op, fn, 16'($urandom), a, b);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
